// File: rtl/stack_pkg.sv
// Shared encodings for the stack engine: push-source selects, pop tags and
// the empty-stack pointer value.
package stack_pkg;

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_PC_HI = 2'b01;
  localparam logic [1:0] SEL_PC_LO = 2'b10;
  localparam logic [1:0] SEL_CCR   = 2'b11;

  typedef enum logic [2:0] {
    TAG_NONE = 3'd0,
    TAG_REG  = 3'd1,
    TAG_PC1  = 3'd2,
    TAG_PC2  = 3'd3,
    TAG_CCR  = 3'd4
  } pop_tag_t;

  // Empty-stack pointer: all ones for the given address width.
  function automatic logic [31:0] sp_reset_val(input int addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/pop_assembler.sv
// Routes returning read data by the tag issued with the read; rebuilds the PC
// from its two halves and produces the one-cycle restore/valid pulses.
module pop_assembler
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32,
  parameter int CCR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  pop_tag_t          tag,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rdata_valid,
  output logic [PC_W-1:0]   pc_restore,
  output logic              pc_restore_valid,
  output logic [CCR_W-1:0]  ccr_restore,
  output logic              ccr_restore_valid
);

  pop_tag_t          tag_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] reg_q;
  logic [PC_W-1:0]   pc_q;
  logic [CCR_W-1:0]  ccr_q;

  // Tag pipeline and holding registers; data lands the cycle after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= TAG_NONE;
      lo_q  <= '0;
      reg_q <= '0;
      pc_q  <= '0;
      ccr_q <= '0;
    end else begin
      tag_q <= tag;
      case (tag_q)
        TAG_REG: reg_q <= mem_rdata;
        TAG_CCR: ccr_q <= mem_rdata[CCR_W-1:0];
        TAG_PC2: lo_q  <= mem_rdata;
        TAG_PC1: pc_q  <= {mem_rdata, lo_q};
        default: ;
      endcase
    end
  end

  // Pulses coincide with the returning data, so the pulse cycle passes it through.
  always_comb begin
    reg_rdata_valid   = 1'b0;
    pc_restore_valid  = 1'b0;
    ccr_restore_valid = 1'b0;
    if (!rst) begin
      case (tag_q)
        TAG_REG: reg_rdata_valid   = 1'b1;
        TAG_PC1: pc_restore_valid  = 1'b1;
        TAG_CCR: ccr_restore_valid = 1'b1;
        default: ;
      endcase
    end
    reg_rdata   = reg_rdata_valid   ? mem_rdata             : reg_q;
    pc_restore  = pc_restore_valid  ? {mem_rdata, lo_q}     : pc_q;
    ccr_restore = ccr_restore_valid ? mem_rdata[CCR_W-1:0]  : ccr_q;
  end

endmodule

// File: rtl/stack_unit.sv
// Memory-stage stack engine and data-memory port arbiter.
// Optional bounds checking is enabled with the STACK_BOUNDS_CHECK_EN macro.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int PC_W   = 32,
  parameter int CCR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack,
  input  logic              MemWR,
  input  logic              MemR,
  input  logic [1:0]        mem_data_sel,
  input  logic              pop_pc1,
  input  logic              pop_pc2,
  input  logic              pop_ccr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [CCR_W-1:0]  ccr_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rdata_valid,
  output logic [PC_W-1:0]   pc_restore,
  output logic              pc_restore_valid,
  output logic [CCR_W-1:0]  ccr_restore,
  output logic              ccr_restore_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] SP_RESET = ADDR_W'(sp_reset_val(ADDR_W));
  localparam logic [ADDR_W-1:0] SP_ONE   = ADDR_W'(1);

  logic        push;
  logic        pop;
  logic        overflow;
  logic        underflow;
  logic        push_ok;
  logic        pop_ok;
  logic [DATA_W-1:0] push_data;
  pop_tag_t    issue_tag;

  assign push = stack & MemWR;
  assign pop  = stack & MemR & ~MemWR;

`ifdef STACK_BOUNDS_CHECK_EN
  assign overflow  = push & (sp == '0);
  assign underflow = pop & (sp == SP_RESET);

  // Sticky bounds error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_err <= 1'b0;
    end else if (overflow || underflow) begin
      stack_err <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
  assign stack_err = 1'b0;
`endif

  assign push_ok = push & ~overflow;
  assign pop_ok  = pop & ~underflow;

  // Push-source mux.
  always_comb begin
    case (mem_data_sel)
      SEL_REG:   push_data = reg_wdata;
      SEL_PC_HI: push_data = pc_in[PC_W-1:DATA_W];
      SEL_PC_LO: push_data = pc_in[DATA_W-1:0];
      SEL_CCR:   push_data = {{(DATA_W-CCR_W){1'b0}}, ccr_in};
      default:   push_data = reg_wdata;
    endcase
  end

  // Memory port drive and pop-tag issue; everything quiet during reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    issue_tag = TAG_NONE;
    if (rst) begin
      issue_tag = TAG_NONE;
    end else if (stack) begin
      if (push_ok) begin
        mem_addr  = sp;
        mem_wdata = push_data;
        mem_we    = 1'b1;
      end else if (pop_ok) begin
        mem_addr = sp + SP_ONE;
        mem_re   = 1'b1;
        if (pop_ccr)      issue_tag = TAG_CCR;
        else if (pop_pc2) issue_tag = TAG_PC2;
        else if (pop_pc1) issue_tag = TAG_PC1;
        else              issue_tag = TAG_REG;
      end else begin
        mem_addr = '0;
      end
    end else begin
      mem_addr  = addr_in;
      mem_wdata = reg_wdata;
      mem_we    = MemWR;
      mem_re    = MemR & ~MemWR;
      issue_tag = (MemR & ~MemWR) ? TAG_REG : TAG_NONE;
    end
  end

  // Stack pointer: post-decrement on push, pre-increment on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (push_ok) begin
      sp <= sp - SP_ONE;
    end else if (pop_ok) begin
      sp <= sp + SP_ONE;
    end
  end

  pop_assembler #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W),
    .CCR_W (CCR_W)
  ) u_pop_assembler (
    .clk              (clk),
    .rst              (rst),
    .tag              (issue_tag),
    .mem_rdata        (mem_rdata),
    .reg_rdata        (reg_rdata),
    .reg_rdata_valid  (reg_rdata_valid),
    .pc_restore       (pc_restore),
    .pc_restore_valid (pc_restore_valid),
    .ccr_restore      (ccr_restore),
    .ccr_restore_valid(ccr_restore_valid)
  );

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit with a synchronous-read memory model.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stack, MemWR, MemR;
  logic [1:0]  mem_data_sel;
  logic        pop_pc1, pop_pc2, pop_ccr;
  logic [10:0] addr_in;
  logic [15:0] reg_wdata;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata;
  logic [15:0] reg_rdata;
  logic        reg_rdata_valid;
  logic [31:0] pc_restore;
  logic        pc_restore_valid;
  logic [2:0]  ccr_restore;
  logic        ccr_restore_valid;
  logic [10:0] sp;
  logic        stack_err;

  logic [15:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_unit dut (
    .clk(clk), .rst(rst), .stack(stack), .MemWR(MemWR), .MemR(MemR),
    .mem_data_sel(mem_data_sel), .pop_pc1(pop_pc1), .pop_pc2(pop_pc2),
    .pop_ccr(pop_ccr), .addr_in(addr_in), .reg_wdata(reg_wdata),
    .pc_in(pc_in), .ccr_in(ccr_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .reg_rdata(reg_rdata),
    .reg_rdata_valid(reg_rdata_valid), .pc_restore(pc_restore),
    .pc_restore_valid(pc_restore_valid), .ccr_restore(ccr_restore),
    .ccr_restore_valid(ccr_restore_valid), .sp(sp), .stack_err(stack_err)
  );

  // Data memory: write and read both on the rising edge; read data is one cycle late.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic idle();
    stack = 1'b0; MemWR = 1'b0; MemR = 1'b0; mem_data_sel = 2'b00;
    pop_pc1 = 1'b0; pop_pc2 = 1'b0; pop_ccr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    addr_in = 11'h000; reg_wdata = 16'h0000; pc_in = 32'h0; ccr_in = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_forced", {31'd0, mem_we}, 32'd0);
    chk("rst_re_forced", {31'd0, mem_re}, 32'd0);

    @(negedge clk); rst = 1'b0; #1;
    chk("reset_sp", {21'd0, sp}, 32'h7FF);
    chk("reset_err", {31'd0, stack_err}, 32'd0);
    chk("reset_pc_restore", pc_restore, 32'd0);
    chk("reset_reg_valid", {31'd0, reg_rdata_valid}, 32'd0);

    // Push PC high, PC low, then CCR.
    @(negedge clk); stack = 1'b1; MemWR = 1'b1; mem_data_sel = 2'b01; pc_in = 32'h0001_0040; #1;
    chk("push_hi_we", {31'd0, mem_we}, 32'd1);
    chk("push_hi_addr", {21'd0, mem_addr}, 32'h7FF);
    chk("push_hi_data", {16'd0, mem_wdata}, 32'h0001);
    @(negedge clk); mem_data_sel = 2'b10; #1;
    chk("push_lo_addr", {21'd0, mem_addr}, 32'h7FE);
    chk("push_lo_data", {16'd0, mem_wdata}, 32'h0040);
    @(negedge clk); mem_data_sel = 2'b11; ccr_in = 3'b101; #1;
    chk("push_ccr_addr", {21'd0, mem_addr}, 32'h7FD);
    chk("push_ccr_data", {16'd0, mem_wdata}, 32'h0005);
    @(negedge clk); idle(); #1;
    chk("push_sp_end", {21'd0, sp}, 32'h7FC);

    // RTI sequence: ccr, pc2, pc1 back to back.
    @(negedge clk); stack = 1'b1; MemR = 1'b1; pop_ccr = 1'b1; #1;
    chk("pop_ccr_re", {31'd0, mem_re}, 32'd1);
    chk("pop_ccr_addr", {21'd0, mem_addr}, 32'h7FD);
    @(negedge clk); pop_ccr = 1'b0; pop_pc2 = 1'b1; #1;
    chk("pop_pc2_addr", {21'd0, mem_addr}, 32'h7FE);
    chk("ccr_valid_n1", {31'd0, ccr_restore_valid}, 32'd1);
    chk("ccr_value", {29'd0, ccr_restore}, 32'h5);
    @(negedge clk); pop_pc2 = 1'b0; pop_pc1 = 1'b1; #1;
    chk("pop_pc1_addr", {21'd0, mem_addr}, 32'h7FF);
    chk("ccr_valid_n2", {31'd0, ccr_restore_valid}, 32'd0);
    chk("pc_valid_n2", {31'd0, pc_restore_valid}, 32'd0);
    @(negedge clk); idle(); #1;
    chk("pc_valid_n3", {31'd0, pc_restore_valid}, 32'd1);
    chk("pc_value", pc_restore, 32'h0001_0040);
    chk("pop_sp_end", {21'd0, sp}, 32'h7FF);
    @(negedge clk); #1;
    chk("pc_valid_drop", {31'd0, pc_restore_valid}, 32'd0);
    chk("pc_value_held", pc_restore, 32'h0001_0040);

    // Ordinary store then load at 0x010.
    @(negedge clk); MemWR = 1'b1; addr_in = 11'h010; reg_wdata = 16'hBEEF; #1;
    chk("store_we", {31'd0, mem_we}, 32'd1);
    chk("store_addr", {21'd0, mem_addr}, 32'h010);
    chk("store_data", {16'd0, mem_wdata}, 32'hBEEF);
    @(negedge clk); MemWR = 1'b0; MemR = 1'b1; #1;
    chk("load_re", {31'd0, mem_re}, 32'd1);
    chk("load_addr", {21'd0, mem_addr}, 32'h010);
    @(negedge clk); idle(); #1;
    chk("load_valid", {31'd0, reg_rdata_valid}, 32'd1);
    chk("load_data", {16'd0, reg_rdata}, 32'hBEEF);
    chk("load_sp", {21'd0, sp}, 32'h7FF);

    // Walk sp down to 0x7F0, then request push and pop together.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); stack = 1'b1; MemWR = 1'b1; reg_wdata = 16'(i);
    end
    @(negedge clk); idle(); #1;
    chk("walk_sp", {21'd0, sp}, 32'h7F0);
    @(negedge clk); stack = 1'b1; MemWR = 1'b1; MemR = 1'b1; pop_pc1 = 1'b1; #1;
    chk("both_we", {31'd0, mem_we}, 32'd1);
    chk("both_re", {31'd0, mem_re}, 32'd0);
    chk("both_addr", {21'd0, mem_addr}, 32'h7F0);
    @(negedge clk); idle(); #1;
    chk("both_sp", {21'd0, sp}, 32'h7EF);
    chk("both_no_pc_valid", {31'd0, pc_restore_valid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk); stack = 1'b1; MemR = 1'b1;
    end
    @(negedge clk); idle(); #1;
    chk("unwind_sp", {21'd0, sp}, 32'h7FF);

    // Pop from an empty stack.
    @(negedge clk); stack = 1'b1; MemR = 1'b1; #1;
`ifdef STACK_BOUNDS_CHECK_EN
    chk("uf_re", {31'd0, mem_re}, 32'd0);
    @(negedge clk); idle(); #1;
    chk("uf_err", {31'd0, stack_err}, 32'd1);
    chk("uf_sp", {21'd0, sp}, 32'h7FF);
    chk("uf_no_valid", {31'd0, reg_rdata_valid}, 32'd0);
`else
    chk("wrap_re", {31'd0, mem_re}, 32'd1);
    chk("wrap_addr", {21'd0, mem_addr}, 32'h000);
    @(negedge clk); idle(); #1;
    chk("wrap_sp", {21'd0, sp}, 32'h000);
    chk("wrap_err", {31'd0, stack_err}, 32'd0);
    chk("wrap_valid", {31'd0, reg_rdata_valid}, 32'd1);
    @(negedge clk); stack = 1'b1; MemWR = 1'b1; #1;
    chk("wrap_push_addr", {21'd0, mem_addr}, 32'h000);
    @(negedge clk); idle(); #1;
    chk("wrap_back_sp", {21'd0, sp}, 32'h7FF);
`endif

    // Reset arriving while a pc1 pop is pending.
    @(negedge clk); stack = 1'b1; MemWR = 1'b1; reg_wdata = 16'h1234;
    @(negedge clk); MemWR = 1'b0; MemR = 1'b1; pop_pc1 = 1'b1; #1;
    chk("pend_pc1_addr", {21'd0, mem_addr}, 32'h7FF);
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("rst_pend_valid", {31'd0, pc_restore_valid}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_valid", {31'd0, pc_restore_valid}, 32'd0);
    chk("post_rst_sp", {21'd0, sp}, 32'h7FF);
    chk("post_rst_err", {31'd0, stack_err}, 32'd0);
    chk("post_rst_pc", pc_restore, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Memory-stage stack engine and data-memory port arbiter. It is the responder for the push/pop request signals that the control unit issues (`stack`, `MemWR`, `MemR`, `mem_data_sel`, `pop_pc1`, `pop_pc2`, `pop_ccr`). It owns the stack pointer, drives the single data-memory port for both stack and ordinary load/store traffic, and reassembles popped PC halves and CCR for the fetch and flag logic.

## Interface
- `DATA_W`, 16: memory word width.
- `ADDR_W`, 11: data-memory address width.
- `PC_W`, 32: PC width; must equal 2×`DATA_W`.
- `CCR_W`, 3: condition-code width.

- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: reset. Synchronous and active-high.
- `stack`  in  1: the current access is a stack access.
- `MemWR`  in  1: write request (a push when `stack`=1).
- `MemR`  in  1: read request (a pop when `stack`=1).
- `mem_data_sel`  in  2: push source. 00 = `reg_wdata`, 01 = PC high half, 10 = PC low half, 11 = CCR, zero-extended.
- `pop_pc1`, `pop_pc2`, `pop_ccr`  in  1 each: destination tag for a pop.
- `addr_in`  in  ADDR_W: load/store address when `stack`=0.
- `reg_wdata`  in  DATA_W: register store data.
- `pc_in`  in  PC_W: PC to push.
- `ccr_in`  in  CCR_W: flags to push.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_we`, `mem_re`  out  1 each: memory write and read strobes.
- `mem_rdata`  in  DATA_W: memory read data, valid one cycle after `mem_re`.
- `reg_rdata`  out  DATA_W: load or plain-pop result.
- `reg_rdata_valid`  out  1: one-cycle pulse marking `reg_rdata` valid.
- `pc_restore`  out  PC_W: reassembled PC.
- `pc_restore_valid`  out  1: one-cycle pulse marking `pc_restore` valid.
- `ccr_restore`  out  CCR_W: popped flags.
- `ccr_restore_valid`  out  1: one-cycle pulse marking `ccr_restore` valid.
- `sp`  out  ADDR_W: current stack pointer.
- `stack_err`  out  1: sticky stack bounds error.

## Operation
- Stack pointer reset value: `SP_RESET` = 2^ADDR_W−1. This value means the stack is empty.
- Push (`stack`&`MemWR`):
  - `mem_addr`=`sp`, `mem_we`=1, `mem_wdata` taken from the `mem_data_sel` mux.
  - `sp` becomes `sp`−1 on the next edge (post-decrement).
- Pop (`stack`&`MemR`&~`MemWR`):
  - `mem_addr`=`sp`+1, `mem_re`=1, and `sp` becomes `sp`+1 (pre-increment).
  - A pop tag is registered with priority ccr > pc2 > pc1 > reg.
- Ordinary access (`stack`=0):
  - `mem_addr`=`addr_in` and `mem_wdata`=`reg_wdata`; `sp` is unchanged.
  - A read registers the tag reg.
- Push and pop requested together: the push executes and the pop is dropped; `sp` only decrements.
- Read-data capture happens in the cycle after `mem_re`, according to the registered tag:
  - reg: `reg_rdata`←`mem_rdata`, pulse `reg_rdata_valid`.
  - ccr: `ccr_restore`←`mem_rdata[CCR_W-1:0]`, pulse `ccr_restore_valid`.
  - pc2: the low-half holding register ←`mem_rdata`; no pulse.
  - pc1: `pc_restore`={`mem_rdata`, low-half register}, pulse `pc_restore_valid`.
- PC order is fixed: push high half then low half; pop low half (pc2) then high half (pc1).
- A pc1 pop with no preceding pc2 uses whatever the low-half register currently holds; this is not an error.
- Address arithmetic on `sp`±1 is modulo 2^ADDR_W.

## Timing
- Reset values: `sp`=`SP_RESET`; `stack_err`, all `*_valid`, `mem_we`, `mem_re`, the pop tag, the low-half register, `pc_restore`, `ccr_restore` and `reg_rdata` are all 0.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_re` are combinational from the request inputs and `sp`; they are forced to 0 while `rst` is high.
- Valid pulses follow the read by exactly one cycle.
- Back-to-back pops, one per cycle, are fully pipelined. The RTI sequence ccr, pc2, pc1 in cycles N..N+2 gives `ccr_restore_valid` at N+1 and `pc_restore_valid` at N+3.
- Reset asserted while a pop is pending discards that pop: no valid pulse appears in the cycle after reset.

## Configuration
- `STACK_BOUNDS_CHECK_EN` defined:
  - A push with `sp`=0 is an overflow; a pop with `sp`=`SP_RESET` is an underflow.
  - In either case the operation is suppressed: no strobe, no `sp` change, no tag, no valid pulse.
  - `stack_err` sets on the next edge and holds until `rst`.
- Not defined: `sp` wraps modulo 2^ADDR_W and `stack_err` is tied to 0.

## Structure
- `stack_pkg` holds:
  - the `mem_data_sel` encodings,
  - the pop-tag enum (NONE, REG, PC1, PC2, CCR),
  - `SP_RESET` as a function of `ADDR_W`.
- One sub-module, `pop_assembler`, contains the tag register, the low-half register, the restore registers and the valid pulses. `stack_unit` contains the SP logic, the address and write-data muxes, and the bounds check.

## Test plan
- After reset, push `pc_in`=0x0001_0040 (sel 01 then 10), then push CCR=3'b101:
  - writes go to 0x7FF=0x0001, 0x7FE=0x0040 and 0x7FD=0x0005;
  - `sp` ends at 0x7FC.
- Pop ccr, pc2 and pc1 in consecutive cycles after that sequence:
  - `ccr_restore`=3'b101 at +1;
  - `pc_restore`=0x0001_0040 at +3;
  - `sp` returns to 0x7FF.
- Load with `stack`=0 and `addr_in`=0x010: `mem_addr`=0x010 and `reg_rdata_valid` pulses one cycle later; `sp` is unchanged.
- Push and pop asserted in the same cycle with `sp`=0x7F0: only `mem_we` is asserted, and `sp` becomes 0x7EF.
- Pop with `sp`=0x7FF:
  - with the macro: no `mem_re`, `stack_err`=1, `sp` stays 0x7FF;
  - without the macro: a read at 0x000 and `sp` becomes 0x000.
- Assert `rst` in the cycle after a pc1 pop: `pc_restore_valid` stays 0 and `sp`=0x7FF.
